// File: rtl/router_pkg.sv
// Shared header layout, timeout constant and FSM encoding for the router output-port reader.
package router_pkg;
  localparam int HDR_LEN_MSB      = 7;
  localparam int HDR_LEN_LSB      = 2;
  localparam int ADDR_W           = 2;
  localparam int SOFT_RST_TIMEOUT = 30;
  localparam int LEN_W            = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int CNT_W            = LEN_W + 1;
  localparam int DLY_W            = $clog2(SOFT_RST_TIMEOUT);

  typedef enum logic [2:0] {IDLE, WAIT, HDR, HDR_CAP, BODY, CHECK} rd_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/router_out_reader_if.sv
// FIFO read handshake plus downstream packet stream of one router output port.
// master = reader side; slave = FIFO/downstream side.
interface router_out_reader_if #(parameter int DWIDTH = 8) ();
  logic              vld_out;
  logic [DWIDTH-1:0] data_out;
  logic              soft_reset;
  logic              hold;
  logic              read_enb;
  logic [DWIDTH-1:0] pkt_data;
  logic              pkt_valid;
  logic              pkt_sop;
  logic              pkt_eop;
  logic              pkt_done;
  logic              parity_err;
  logic              pkt_abort;
  logic [15:0]       pkt_cnt;
  logic [15:0]       err_cnt;

  modport master (
    input  vld_out, data_out, soft_reset, hold,
    output read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_done,
           parity_err, pkt_abort, pkt_cnt, err_cnt
  );

  modport slave (
    output vld_out, data_out, soft_reset, hold,
    input  read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_done,
           parity_err, pkt_abort, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/router_parity_acc.sv
// XOR parity accumulator: load with header, fold in payload, latch parity byte, compare.
// Result valid the cycle after the parity byte is latched; no backpressure.
module router_parity_acc #(parameter int DWIDTH = 8) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              acc_en,
  input  logic              par_en,
  input  logic [DWIDTH-1:0] dat,
  output logic              mismatch
);
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      par <= '0;
    end else begin
      if (load)        acc <= dat;
      else if (acc_en) acc <= acc ^ dat;
      if (par_en)      par <= dat;
    end
  end

  assign mismatch = (acc != par);
endmodule

// File: rtl/router_out_reader.sv
// Router output-port reader: pulls a packet from the FIFO, streams it with sop/eop, checks parity
// (only when ROUT_PARITY_CHK_EN is defined). Byte out 1 cycle after read_enb; hold stalls issue only.
module router_out_reader
  import router_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int START_DLY = 0
) (
  input  logic                clock,
  input  logic                resetn,
  router_out_reader_if.master bus
);
  rd_state_t        state, state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [CNT_W-1:0] remaining, issued, rcvd;
  logic             rd_en, rd_q;
  logic             active, capture, last_byte, par_err;
  logic [15:0]      pkt_cnt_r, err_cnt_r;

  assign active    = (state != IDLE);
  // A read issued last cycle is only delivered if the packet is still alive.
  assign capture   = rd_q & ~bus.soft_reset & ((state == HDR_CAP) | (state == BODY));
  assign last_byte = (state == BODY) & ((rcvd + CNT_W'(1)) == remaining);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:    if (bus.vld_out) state_nxt = WAIT;
      // Delay of N gives the first read N+1 cycles after vld_out is seen; 0 and 1 both take one WAIT cycle.
      WAIT:    if (dly_cnt <= DLY_W'(1)) state_nxt = HDR;
      HDR: begin
        rd_en = bus.vld_out & ~bus.hold;
        if (rd_en) state_nxt = HDR_CAP;
      end
      HDR_CAP: state_nxt = BODY;
      BODY: begin
        rd_en = bus.vld_out & ~bus.hold & (issued < remaining);
        if (capture && last_byte) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.soft_reset && active) begin
      state_nxt = IDLE;
      rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      remaining <= '0;
      issued    <= '0;
      rcvd      <= '0;
      rd_q      <= 1'b0;
      pkt_cnt_r <= '0;
      err_cnt_r <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= rd_en;
      if (state == IDLE && bus.vld_out)    dly_cnt <= DLY_W'(START_DLY);
      else if (state == WAIT && dly_cnt != '0) dly_cnt <= dly_cnt - DLY_W'(1);
      if (state == HDR_CAP) begin
        remaining <= CNT_W'(bus.data_out[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);
        issued    <= '0;
        rcvd      <= '0;
      end else if (state == BODY) begin
        issued <= issued + CNT_W'(rd_en);
        rcvd   <= rcvd + CNT_W'(capture);
      end
      if (bus.soft_reset && active)     err_cnt_r <= sat_inc(err_cnt_r);
      else if (state == CHECK && par_err) err_cnt_r <= sat_inc(err_cnt_r);
      else if (state == CHECK)            pkt_cnt_r <= sat_inc(pkt_cnt_r);
    end
  end

`ifdef ROUT_PARITY_CHK_EN
  logic par_mismatch;

  router_parity_acc #(.DWIDTH(DWIDTH)) u_parity_acc (
    .clk      (clock),
    .rst_n    (resetn),
    .load     (capture & (state == HDR_CAP)),
    .acc_en   (capture & (state == BODY) & ~last_byte),
    .par_en   (capture & last_byte),
    .dat      (bus.data_out),
    .mismatch (par_mismatch)
  );
  assign par_err = par_mismatch;
`else
  assign par_err = 1'b0;
`endif

  assign bus.read_enb   = rd_en;
  assign bus.pkt_valid  = capture;
  assign bus.pkt_data   = capture ? bus.data_out : '0;
  assign bus.pkt_sop    = capture & (state == HDR_CAP);
  assign bus.pkt_eop    = capture & last_byte;
  assign bus.pkt_done   = (state == CHECK) & ~bus.soft_reset;
  assign bus.parity_err = bus.pkt_done & par_err;
  assign bus.pkt_abort  = bus.soft_reset & active;
  assign bus.pkt_cnt    = pkt_cnt_r;
  assign bus.err_cnt    = err_cnt_r;
endmodule
